// File: rtl/genius_control.sv
// -----------------------------------------------------------------------------
// genius_control
// Control FSM for a "Genius" (Simon-style) memory game. It sequences the
// datapath through setup, FPGA sequence playback, user entry, checking and
// result display. The pushbutton input is synchronized and edge-detected here.
//
// Optional feature macro: GENIUS_TIMEOUT_EN
//   defined   -> end_time=1 in PLAY (with end_User=0) ends the game (RESULT)
//   undefined -> end_time is ignored everywhere; PLAY leaves only on end_User
//
// Parameter
//   P_SYNC    number of synchronizer flops on enter (legal values: 2 or 3)
//
// Ports
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   synchronous, active-low reset
//   enter     in   raw asynchronous active-low pushbutton (start/confirm)
//   end_FPGA  in   FPGA sequence playback finished
//   end_User  in   user finished entering the sequence
//   end_time  in   user entry timed out
//   win       in   final round reached
//   match     in   user entry matched the FPGA sequence
//   R1        out  game-scope datapath reset
//   R2        out  round-scope datapath reset
//   E1        out  setup register enable
//   E2        out  user entry / timer enable
//   E3        out  FPGA sequence enable
//   E4        out  round counter enable
//   SEL       out  display select (1 = game view, 0 = result view)
//   state_o   out  current state encoding
// -----------------------------------------------------------------------------
module genius_control #(
  parameter int P_SYNC = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_SETUP    = 3'd1,
    S_PREP     = 3'd2,
    S_SEQUENCE = 3'd3,
    S_PLAY     = 3'd4,
    S_CHECK    = 3'd5,
    S_NEXT     = 3'd6,
    S_RESULT   = 3'd7
  } state_t;

  // ---------------------------------------------------------------------------
  // Enter conditioning: P_SYNC-stage synchronizer, then a registered 1->0 edge
  // detector. All stages reset to 1 (button released), so a key that is
  // already released when reset ends never produces a spurious press.
  // ---------------------------------------------------------------------------
  logic [P_SYNC-1:0] sync_q;
  logic              edge_q;
  logic              press_q;

  genvar gi;
  generate
    for (gi = 0; gi < P_SYNC; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge CLOCK_50) begin
          if (!reset) sync_q[gi] <= 1'b1;
          else        sync_q[gi] <= enter;
        end
      end else begin : g_rest
        always_ff @(posedge CLOCK_50) begin
          if (!reset) sync_q[gi] <= 1'b1;
          else        sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // The press pulse is registered so the FSM sees it P_SYNC+1 cycles after
  // the key falls; a held key stays low in the chain and yields one pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      edge_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      edge_q  <= sync_q[P_SYNC-1];
      press_q <= edge_q & ~sync_q[P_SYNC-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The press pulse is consumed only in SETUP and RESULT;
  // everywhere else it is simply dropped, never latched.
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     state_d = S_SETUP;
      S_SETUP:    if (press_q) state_d = S_PREP;
      S_PREP:     state_d = S_SEQUENCE;
      S_SEQUENCE: if (end_FPGA) state_d = S_PLAY;
      S_PLAY: begin
        if (end_User) begin
          state_d = S_CHECK;          // user completion wins over timeout
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (end_time) begin
          state_d = S_RESULT;
        end
`endif
      end
      S_CHECK: begin
        if (match && !win) state_d = S_NEXT;
        else               state_d = S_RESULT;
      end
      S_NEXT:     state_d = S_PREP;
      S_RESULT:   if (press_q) state_d = S_INIT;
      default:    state_d = S_INIT;
    endcase
  end

`ifndef GENIUS_TIMEOUT_EN
  // end_time has no effect in this build.
  logic unused_end_time;
  assign unused_end_time = end_time;
`endif

  // Output decode, packed as {R1, R2, E1, E2, E3, E4, SEL}.
  function automatic logic [6:0] decode_outs(input state_t s);
    logic [6:0] o;
    o = 7'b0000000;
    case (s)
      S_INIT:     o = 7'b1100001;
      S_SETUP:    o = 7'b0010001;
      S_PREP:     o = 7'b0100001;
      S_SEQUENCE: o = 7'b0000101;
      S_PLAY:     o = 7'b0001001;
      S_CHECK:    o = 7'b0000001;
      S_NEXT:     o = 7'b0000011;
      S_RESULT:   o = 7'b0000000;
      default:    o = 7'b0000000;
    endcase
    return o;
  endfunction

  // State and outputs are registered together: outputs are decoded from the
  // state being loaded, so they always match state_q and never depend
  // combinationally on an input.
  logic [6:0] outs_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= S_INIT;
      outs_q  <= decode_outs(S_INIT);
    end else begin
      state_q <= state_d;
      outs_q  <= decode_outs(state_d);
    end
  end

  assign {R1, R2, E1, E2, E3, E4, SEL} = outs_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_genius_control.sv
// -----------------------------------------------------------------------------
// tb_genius_control
// Self-checking bench for genius_control. A table of {inputs, expected state}
// records drives the main flows; hand-written sequences cover the timeout
// branch and a mid-round reset. Every step queues the expected state/outputs
// when inputs are driven and compares them one clock later.
// -----------------------------------------------------------------------------
module tb_genius_control;

  localparam int P_SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic       enter;
  logic       end_fpga;
  logic       end_user;
  logic       end_time;
  logic       win;
  logic       match;
  logic       r1, r2, e1, e2, e3, e4, sel;
  logic [2:0] state;

  genius_control #(.P_SYNC(P_SYNC)) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .enter    (enter),
    .end_FPGA (end_fpga),
    .end_User (end_user),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (r1),
    .R2       (r2),
    .E1       (e1),
    .E2       (e2),
    .E3       (e3),
    .E4       (e4),
    .SEL      (sel),
    .state_o  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       enter;
    logic       efpga;
    logic       euser;
    logic       etime;
    logic       win;
    logic       match;
    logic [2:0] exp_state;
    int         rep;
    string      tag;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [6:0] outs;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_steps  = 0;

  // Expected outputs per state, packed {R1,R2,E1,E2,E3,E4,SEL}.
  function automatic logic [6:0] model_outs(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b1100001;
      3'd1:    return 7'b0010001;
      3'd2:    return 7'b0100001;
      3'd3:    return 7'b0000101;
      3'd4:    return 7'b0001001;
      3'd5:    return 7'b0000001;
      3'd6:    return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void add(input logic r, en, ef, eu, et, w, m,
                              input logic [2:0] es, input int rep,
                              input string tag);
    vec_t v;
    v.rst_n = r; v.enter = en; v.efpga = ef; v.euser = eu; v.etime = et;
    v.win = w; v.match = m; v.exp_state = es; v.rep = rep; v.tag = tag;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge: drive inputs, queue the expectation for the
  // next rising edge, then compare at the following falling edge.
  task automatic step(input logic r, en, ef, eu, et, w, m,
                      input logic [2:0] es, input string tag);
    exp_t e;
    exp_t got;
    logic [6:0] act;
    e.st = es; e.outs = model_outs(es); e.tag = tag;
    sb_q.push_back(e);
    rst_n = r; enter = en; end_fpga = ef; end_user = eu; end_time = et;
    win = w; match = m;
    @(negedge clk);
    n_steps++;
    got = sb_q.pop_front();
    act = {r1, r2, e1, e2, e3, e4, sel};
    n_checks++;
    if (state !== got.st) begin
      n_fails++;
      $display("FAIL %s state: got %0d expected %0d (step %0d)",
               got.tag, state, got.st, n_steps);
    end
    n_checks++;
    if (act !== got.outs) begin
      n_fails++;
      $display("FAIL %s outputs R1R2E1E2E3E4SEL: got %b expected %b (step %0d)",
               got.tag, act, got.outs, n_steps);
    end
    $display("step %0d %s: state=%0d outs=%b", n_steps, got.tag, state, act);
  endtask

  task automatic idle(input logic [2:0] es, input int n, input string tag);
    for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0, 0, 0, es, tag);
  endtask

  // Enter held low: pulse after P_SYNC+1 edges, state moves on edge P_SYNC+2.
  task automatic press(input logic [2:0] from_s, input logic [2:0] to_s,
                       input string tag);
    for (int k = 0; k < P_SYNC + 1; k++) step(1, 0, 0, 0, 0, 0, 0, from_s, tag);
    step(1, 0, 0, 0, 0, 0, 0, to_s, tag);
  endtask

  initial begin
    rst_n = 1'b0; enter = 1'b1; end_fpga = 1'b0; end_user = 1'b0;
    end_time = 1'b0; win = 1'b0; match = 1'b0;

    //   rst en ef eu et w  m  exp rep tag
    add(0, 1, 0, 0, 0, 0, 0, 3'd0, 2,  "reset");
    add(1, 1, 0, 0, 0, 0, 0, 3'd1, 3,  "release_setup");
    add(1, 0, 0, 0, 0, 0, 0, 3'd1, P_SYNC + 1, "hold_sync");
    add(1, 0, 0, 0, 0, 0, 0, 3'd2, 1,  "hold_prep");
    add(1, 0, 0, 0, 0, 0, 0, 3'd3, 40 - (P_SYNC + 2), "hold_seq");
    add(1, 1, 0, 0, 0, 0, 0, 3'd3, 3,  "seq_wait");
    add(1, 1, 1, 0, 0, 0, 0, 3'd4, 1,  "end_fpga");
    add(1, 1, 0, 0, 0, 0, 0, 3'd4, 2,  "play_wait");
    add(1, 1, 0, 1, 0, 0, 1, 3'd5, 1,  "user_done_match");
    add(1, 1, 0, 0, 0, 0, 1, 3'd6, 1,  "check_next");
    add(1, 1, 0, 0, 0, 0, 0, 3'd2, 1,  "next_prep");
    add(1, 1, 0, 0, 0, 0, 0, 3'd3, 1,  "prep_seq");
    add(1, 1, 1, 0, 0, 0, 0, 3'd4, 1,  "end_fpga2");
    add(1, 1, 0, 1, 1, 0, 1, 3'd5, 1,  "user_and_time");
    add(1, 1, 0, 0, 0, 0, 1, 3'd6, 1,  "check_next2");
    add(1, 1, 0, 0, 0, 0, 0, 3'd2, 1,  "next_prep2");
    add(1, 1, 0, 0, 0, 0, 0, 3'd3, 1,  "prep_seq2");
    add(1, 1, 1, 0, 0, 0, 0, 3'd4, 1,  "end_fpga3");
    add(1, 1, 0, 1, 0, 0, 0, 3'd5, 1,  "user_done_miss");
    add(1, 1, 0, 0, 0, 0, 0, 3'd7, 3,  "check_result");
    add(1, 0, 0, 0, 0, 0, 0, 3'd7, P_SYNC + 1, "result_press");
    add(1, 0, 0, 0, 0, 0, 0, 3'd0, 1,  "result_init");
    add(1, 0, 0, 0, 0, 0, 0, 3'd1, 10, "held_one_pulse");
    add(1, 1, 0, 0, 0, 0, 0, 3'd1, 2,  "release");
    add(1, 0, 0, 0, 0, 0, 0, 3'd1, P_SYNC + 1, "setup_press");
    add(1, 0, 0, 0, 0, 0, 0, 3'd2, 1,  "setup_prep");
    add(1, 1, 0, 0, 0, 0, 0, 3'd3, 2,  "seq");
    add(1, 1, 1, 0, 0, 0, 0, 3'd4, 1,  "end_fpga4");
    add(1, 1, 0, 1, 0, 1, 1, 3'd5, 1,  "user_done_win");
    add(1, 1, 0, 0, 0, 1, 1, 3'd7, 1,  "check_win");
    add(1, 1, 0, 0, 0, 0, 0, 3'd7, 1,  "result_hold");

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].rep; k++) begin
        step(vecs[i].rst_n, vecs[i].enter, vecs[i].efpga, vecs[i].euser,
             vecs[i].etime, vecs[i].win, vecs[i].match, vecs[i].exp_state,
             vecs[i].tag);
      end
    end

    // Timeout branch in PLAY.
    press(3'd7, 3'd0, "to_restart");
    step(1, 1, 0, 0, 0, 0, 0, 3'd1, "to_setup");
    idle(3'd1, 2, "to_setup_idle");
    press(3'd1, 3'd2, "to_start");
    step(1, 1, 0, 0, 0, 0, 0, 3'd3, "to_seq");
    step(1, 1, 1, 0, 0, 0, 0, 3'd4, "to_play");
`ifdef GENIUS_TIMEOUT_EN
    step(1, 1, 0, 0, 1, 0, 0, 3'd7, "timeout");
    idle(3'd7, 2, "timeout_after");
`else
    step(1, 1, 0, 0, 1, 0, 0, 3'd4, "timeout_ignored");
    idle(3'd4, 2, "timeout_after");
`endif
    step(0, 1, 0, 0, 0, 0, 0, 3'd0, "to_reset");
    idle(3'd1, 2, "to_reset_release");

    // Press during SEQUENCE is dropped; reset mid-round returns to INIT.
    press(3'd1, 3'd2, "mr_start");
    step(1, 1, 0, 0, 0, 0, 0, 3'd3, "mr_seq");
    idle(3'd3, 2, "mr_seq_idle");
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0, 0, 0, 3'd3, "mr_seq_press");
    idle(3'd3, 2, "mr_seq_release");
    step(0, 1, 0, 0, 0, 0, 0, 3'd0, "mr_reset");
    idle(3'd1, 6, "mr_no_stored_press");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d steps", n_steps);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/genius_control.md
GENIUS_CONTROL -- requirements
Module: genius_control

Interface
REQ-001 Parameter P_SYNC, default 2, sets the number of synchronizer flops on enter; legal values are 2 and 3.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; 0 at a rising CLOCK_50 edge resets the block.
REQ-004 enter  input  1  raw, asynchronous, active-low pushbutton (start/confirm).
REQ-005 end_FPGA, end_User, end_time, win, match  input  1 each  datapath status flags, sampled synchronously.
REQ-006 R1, R2  output  1 each  datapath resets: R1 = game scope, R2 = round scope.
REQ-007 E1, E2, E3, E4  output  1 each  enables: setup register, user entry/time, FPGA sequence, round counter.
REQ-008 SEL  output  1  display select: 1 = game view, 0 = result view.
REQ-009 state_o  output  3  current state encoding.

Function
REQ-010 Enter conditioning shall pass enter through P_SYNC flops (reset value 1), then detect a 1->0 transition, giving a one-cycle press pulse.
REQ-011 The press pulse shall appear P_SYNC+1 cycles after enter falls; a held key gives exactly one pulse.
REQ-012 States and encodings: INIT=0, SETUP=1, PREP=2, SEQUENCE=3, PLAY=4, CHECK=5, NEXT=6, RESULT=7.
REQ-013 Outputs shall be Moore-decoded from the state register only; no input-to-output combinational path.
REQ-014 INIT: R1=1, R2=1, SEL=1; next state SETUP unconditionally.
REQ-015 SETUP: E1=1, SEL=1; press -> PREP, else stay.
REQ-016 PREP: R2=1, SEL=1, exactly one cycle; -> SEQUENCE.
REQ-017 SEQUENCE: E3=1, SEL=1; end_FPGA=1 -> PLAY, else stay.
REQ-018 PLAY: E2=1, SEL=1; end_User=1 -> CHECK; else end_time=1 -> RESULT (only when timeout is enabled, see REQ-026); else stay.
REQ-019 If end_User and end_time are both 1 in PLAY, end_User shall take priority (-> CHECK).
REQ-020 CHECK: all enables 0, SEL=1, one cycle. match=0 -> RESULT; match=1 with win=1 -> RESULT; match=1 with win=0 -> NEXT.
REQ-021 NEXT: E4=1, SEL=1, exactly one cycle; -> PREP.
REQ-022 RESULT: SEL=0, all R and E outputs 0; press -> INIT, else stay.
REQ-023 Any output not named for a state shall be 0 in that state.
REQ-024 Presses in states other than SETUP and RESULT shall be ignored and shall not be stored.

Reset
REQ-025 reset=0 at a clock edge shall force state INIT and all synchronizer and edge flops to 1, from any state, including mid-round. The cycle after reset, outputs shall be R1=1, R2=1, SEL=1, E1..E4=0, state_o=0.

Configuration
REQ-026 Macro GENIUS_TIMEOUT_EN. When defined, end_time=1 in PLAY (with end_User=0) shall go to RESULT. When undefined, end_time shall be ignored in every state and PLAY shall leave only on end_User. All other behaviour is identical in both builds.

Verification
REQ-027 Reset release, then 3 idle cycles -> state_o goes 0 then 1; R1=R2=1 only in the INIT cycle; E1=1 from cycle 2.
REQ-028 In SETUP, hold enter low for 40 cycles -> exactly one transition to PREP, P_SYNC+2 cycles after the fall (P_SYNC+1 cycles to the pulse, plus 1 for the state register); R2=1 for 1 cycle; then SEQUENCE with E3=1.
REQ-029 In SEQUENCE, pulse end_FPGA; in PLAY, pulse end_User with match=1, win=0 -> CHECK, then NEXT (E4=1 for 1 cycle), then PREP, then SEQUENCE.
REQ-030 In PLAY, pulse end_User with match=0 -> CHECK, then RESULT with SEL=0; enter press -> INIT.
REQ-031 In PLAY, drive end_time=1 with end_User=0 -> RESULT when GENIUS_TIMEOUT_EN is defined; state stays 4 when it is undefined. end_time=end_User=1 -> CHECK in both builds.
REQ-032 In SEQUENCE, assert reset=0 for 1 cycle -> state_o=0 on the next edge, then SETUP; an enter press during SEQUENCE produces no later transition.
